// File: rtl/stream_wr_pkg.sv
// Shared types and constants for the stream write sequencer.
// Imported by the interfaces, the skid buffer and the top.
package stream_wr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam int ERR_UNDER = 0;
  localparam int ERR_OVER  = 1;
  localparam int NUM_ERR   = 2;

  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/stream_wr_if.sv
// Input AXI-Stream bundle and memory write-port bundle.
// Both interfaces carry master/slave modports.
interface stream_wr_axis_if
  import stream_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) ();
  localparam int SW = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] tdata;
  logic [SW-1:0]         tstrb;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tdata, tstrb, tvalid, tlast,
    input  tready
  );
  modport slave (
    input  tdata, tstrb, tvalid, tlast,
    output tready
  );
endinterface

interface stream_wr_mem_if
  import stream_wr_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) ();
  localparam int SW = strb_width(DATA_WIDTH);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_tdata;
  logic [SW-1:0]         tstrb;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output wr_en, wr_addr, wr_tdata,
    output tstrb, tvalid, tlast,
    input  tready
  );
  modport slave (
    input  wr_en, wr_addr, wr_tdata,
    input  tstrb, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/stream_wr_skid.sv
// Two-entry skid buffer; head entry drives the output registers.
// Exposes next-cycle full/empty so the caller can register its ready.
module stream_wr_skid #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         full_d_o,
  output logic         empty_d_o
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] e0_q, e1_q;
  logic         pop;

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = e0_q;
  assign pop         = out_ready_i & out_valid_o;
  assign full_d_o    = (cnt_d == 2'd2);
  assign empty_d_o   = (cnt_d == 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    case ({in_valid_i, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      // head only moves on a pop, or loads when it is free
      if (pop && cnt_q == 2'd2)
        e0_q <= e1_q;
      else if (in_valid_i &&
               (cnt_q == 2'd0 ||
                (pop && cnt_q == 2'd1)))
        e0_q <= in_data_i;
      if (in_valid_i &&
          (cnt_q == 2'd2 ||
           (cnt_q == 2'd1 && !pop)))
        e1_q <= in_data_i;
    end
  end

endmodule

// File: rtl/stream_wr_sequencer.sv
// Packet-to-memory write sequencer with FSM and address counter.
// STREAM_WR_PKT_CNT_EN adds the completed-packet counter port.
module stream_wr_sequencer
  import stream_wr_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
`ifdef STREAM_WR_PKT_CNT_EN
  , parameter int PKT_CNT_WIDTH = 16
`endif
) (
  input  logic                  axis_aclk,
  input  logic                  axis_areset,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  stream_wr_axis_if.slave       s01_axis,
  stream_wr_mem_if.master       m01_axis,
  output logic                  busy,
  output logic                  done,
  output logic                  err_underflow,
  output logic                  err_overflow
`ifdef STREAM_WR_PKT_CNT_EN
  , output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
`endif
);

  localparam int SW = strb_width(DATA_WIDTH);
  localparam int W  = ADDR_WIDTH + DATA_WIDTH + SW;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d, idx_inc;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [NUM_ERR-1:0]    err_q, err_d;
  logic                  tready_q, busy_q, done_q;
  logic                  acc, wr, push;
  logic                  sk_valid, sk_full_d, sk_empty_d;
  logic [W-1:0]          sk_in, sk_out;

  assign acc     = s01_axis.tvalid & tready_q;
  assign wr      = |s01_axis.tstrb;
  assign idx_inc = idx_q + (ADDR_WIDTH+1)'(1);
  assign sk_in   = {base_q + idx_q[ADDR_WIDTH-1:0],
                    s01_axis.tdata, s01_axis.tstrb};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: if (cfg_start) begin
        idx_d = '0;
        err_d = '0;
        if (cfg_len == '0) begin
          err_d[ERR_UNDER] = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: if (acc) begin
        if (wr) begin
          push  = 1'b1;
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            if (s01_axis.tlast) begin
              state_d = S_FLUSH;
            end else begin
              err_d[ERR_OVER] = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (s01_axis.tlast) begin
            err_d[ERR_UNDER] = 1'b1;
            state_d = S_FLUSH;
          end
        end else if (s01_axis.tlast) begin
          // idx < len always holds in RUN, so this is short
          err_d[ERR_UNDER] = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_DRAIN: if (acc && s01_axis.tlast) state_d = S_FLUSH;
      S_FLUSH: if (sk_empty_d) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      err_q    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && cfg_start) begin
        base_q <= cfg_base_addr;
        len_q  <= cfg_len;
      end
      tready_q <= (state_d == S_RUN ||
                   state_d == S_DRAIN) && !sk_full_d;
      busy_q   <= (state_d == S_RUN ||
                   state_d == S_DRAIN ||
                   state_d == S_FLUSH);
      done_q   <= (state_d == S_DONE);
    end
  end

  stream_wr_skid #(.W(W)) u_skid (
    .clk         (axis_aclk),
    .rst         (axis_areset),
    .in_valid_i  (push),
    .in_data_i   (sk_in),
    .out_ready_i (m01_axis.tready),
    .out_valid_o (sk_valid),
    .out_data_o  (sk_out),
    .full_d_o    (sk_full_d),
    .empty_d_o   (sk_empty_d)
  );

  assign {m01_axis.wr_addr,
          m01_axis.wr_tdata,
          m01_axis.tstrb}  = sk_out;
  assign m01_axis.wr_en    = sk_valid;
  assign m01_axis.tvalid   = sk_valid;
  assign m01_axis.tlast    = sk_valid;
  assign s01_axis.tready   = tready_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err_underflow     = err_q[ERR_UNDER];
  assign err_overflow      = err_q[ERR_OVER];

`ifdef STREAM_WR_PKT_CNT_EN
  logic [PKT_CNT_WIDTH-1:0] pkt_q;

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset)
      pkt_q <= '0;
    else if (state_d == S_DONE)
      pkt_q <= pkt_q + PKT_CNT_WIDTH'(1);
  end

  assign pkt_cnt = pkt_q;
`endif

endmodule

// File: doc/stream_wr_sequencer.md
# stream_wr_sequencer

Write-side sequencer sitting directly upstream of the dual-clock word memory's write port. Accepts an AXI-Stream packet on its slave port and assigns each valid beat a consecutive memory address starting from a programmed base. Presents the beats as single-word memory writes on its master port through a 2-entry skid buffer. Reports completion, short-packet and overlong-packet conditions to the control logic.

## Interface
- ADDR_WIDTH, 12, memory word-address width (memory depth 2^ADDR_WIDTH)
- DATA_WIDTH, 32, stream/memory data width; multiple of 8
- PKT_CNT_WIDTH, 16, width of completed-packet counter (macro build only)

- axis_aclk  in  1  single clock for all logic
- axis_areset  in  1  asynchronous, active-high reset
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE
- cfg_base_addr  in  ADDR_WIDTH  first write address, latched on accepted start
- cfg_len  in  ADDR_WIDTH+1  maximum words to write (1..2^ADDR_WIDTH), latched on accepted start
- s01_axis_tdata  in  DATA_WIDTH  input beat data
- s01_axis_tstrb  in  DATA_WIDTH/8  input byte strobes
- s01_axis_tvalid  in  1  input beat valid
- s01_axis_tlast  in  1  last beat of packet
- s01_axis_tready  out  1  sequencer can accept a beat
- m01_axis_wr_en  out  1  memory write enable; equals m01_axis_tvalid
- m01_axis_wr_addr  out  ADDR_WIDTH  memory write address
- m01_axis_wr_tdata  out  DATA_WIDTH  memory write data
- m01_axis_tstrb  out  DATA_WIDTH/8  strobes passed through from input beat
- m01_axis_tvalid  out  1  write beat valid
- m01_axis_tlast  out  1  asserted with every valid write beat (memory commits per word)
- m01_axis_tready  in  1  memory-side ready
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- err_underflow  out  1  sticky: packet ended before cfg_len words
- err_overflow  out  1  sticky: cfg_len reached before tlast
- pkt_cnt  out  PKT_CNT_WIDTH  completed packets (only with macro)

## Operation
- FSM states: IDLE, RUN, DRAIN, FLUSH, DONE.
- IDLE: s01_axis_tready=0. cfg_start=1 latches base/len, clears both error flags, counter idx=0, and moves to RUN. If cfg_len=0, the start is accepted, err_underflow is set, and the FSM moves directly to DONE.
- RUN: beat accepted when s01_axis_tvalid & s01_axis_tready. Beats with tstrb==0 are consumed but not written and not counted. A written beat gets addr = (base + idx) mod 2^ADDR_WIDTH, after which idx increments.
  - Accepted beat with tlast and idx+1 < len (written) -> set err_underflow, go to FLUSH.
  - idx+1 == len and tlast -> FLUSH, no error.
  - idx+1 == len without tlast -> set err_overflow, go to DRAIN.
  - tlast on a zero-strobe beat follows the same rules using the current idx.
- DRAIN: s01_axis_tready=1. Beats are discarded until an accepted tlast, then FLUSH.
- FLUSH: s01_axis_tready=0. Wait until the skid buffer is empty, then go to DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- cfg_start outside IDLE is ignored.
- Address wrap past 2^ADDR_WIDTH-1 to 0 is silent and legal.

## Timing
- Reset values: every output is 0 (all data/address buses, tvalid, tlast, wr_en, tready, busy, done, errors, pkt_cnt). FSM goes to IDLE and the buffer is emptied immediately and asynchronously. Reset mid-transfer discards buffered beats with no partial done pulse.
- Latency: accepted input beat appears on m01_axis_* the next cycle when the buffer is empty.
- s01_axis_tready is registered: high in RUN/DRAIN when at least one buffer slot is free after the current cycle.
- Sustained throughput of 1 beat/cycle while m01_axis_tready=1.
- m01_axis_* is held stable while tvalid=1 and tready=0. A beat retires when tvalid & tready.
- Simultaneous input accept and output retire with a full buffer are legal; occupancy is unchanged.
- busy rises the cycle after an accepted cfg_start.
- done is asserted the cycle after the last write retires. Minimum start-to-done for len=1 with ready always high is 4 cycles.

## Configuration
- STREAM_WR_PKT_CNT_EN defined: pkt_cnt port and counter exist. The counter increments on each DONE, including error cases, and wraps modulo 2^PKT_CNT_WIDTH.
- STREAM_WR_PKT_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package stream_wr_pkg: FSM state enum type, strobe width constant DATA_WIDTH/8 derivation, error-flag bit indices.
- One sub-module, stream_wr_skid: 2-entry skid buffer carrying {addr, data, strb} with valid/ready on both sides. The FSM and address counter live in the top.

## Test plan
- Base 0x010, len 4, 4-beat packet (data 0xA0..0xA3, strb 0xF, tlast on beat 4), ready high -> writes to 0x010..0x013 with matching data, tlast=1 on each, done once, no errors.
- Base 0xFFE, len 4, 4-beat packet -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Len 8, packet of 3 beats -> 3 writes, err_underflow=1, done; err_overflow=0.
- Len 2, packet of 5 beats -> 2 writes at base, beats 3–5 accepted and discarded, err_overflow=1, done after tlast.
- Len 4, m01_axis_tready toggled 1-0-0-1 each cycle, input continuous -> no beat lost or duplicated, outputs stable while stalled, s01_axis_tready drops when buffer holds 2.
- Assert axis_areset while 1 beat is buffered mid-packet -> all outputs 0 immediately. A new start with base 0x100, len 1 then writes only to 0x100; pkt_cnt (macro build) unchanged by the aborted transfer.
